ddram_responder: RTL
====================

DDRAM_RESPONDER -- requirements
Module: ddram_responder

Interface
REQ-001 SHALL have parameter AW, default 10: log2 of backing-store depth, in 64-bit words.
REQ-002 SHALL have parameter BASE, default 29'h0600_0000: word address of store word 0 (byte 0x30000000).
REQ-003 SHALL have parameter RD_LAT, default 2, range 1..15: cycles from read acceptance to the first read beat.
REQ-004 SHALL have parameter STALL_EN, default 0: enables pseudo-random BUSY insertion.
REQ-005 SHALL have port DDRAM_CLK, in, 1: sole clock.
REQ-006 SHALL have port RESET, in, 1: reset; asynchronous, active-high.
REQ-007 SHALL have port DDRAM_BUSY, out, 1: commands and write beats are not accepted while high.
REQ-008 SHALL have port DDRAM_BURSTCNT, in, 8: burst length in beats.
REQ-009 SHALL have port DDRAM_ADDR, in, 29: 64-bit word address.
REQ-010 SHALL have port DDRAM_RD, in, 1: read request.
REQ-011 SHALL have port DDRAM_WE, in, 1: write request or write beat.
REQ-012 SHALL have port DDRAM_DIN, in, 64: write data.
REQ-013 SHALL have port DDRAM_BE, in, 8: byte enables; bit i enables DIN[8i+7:8i].
REQ-014 SHALL have port DDRAM_DOUT, out, 64: read data.
REQ-015 SHALL have port DDRAM_DOUT_READY, out, 1: DOUT valid; one beat per high cycle.

Function
REQ-016 SHALL implement states IDLE, WBURST, RLAT and RBURST.
REQ-017 SHALL accept a command in IDLE on any edge where BUSY=0 and RD or WE is high, latching ADDR and BURSTCNT.
REQ-018 SHALL treat BURSTCNT=0 as 1.
REQ-019 SHALL give WE priority when RD and WE are high together; that RD is dropped.
REQ-020 SHALL, on write acceptance, write beat 0 to the accepted address, honouring BE per byte.
REQ-021 SHALL go to WBURST if the burst is longer than 1 beat, otherwise stay in IDLE.
REQ-022 SHALL, in WBURST, accept a beat on each edge where WE=1 and BUSY=0, and SHALL increment the address per beat.
REQ-023 SHALL treat WE=0 cycles in WBURST as wait states, ignore RD in WBURST, and return to IDLE after the last beat.
REQ-024 SHALL, on read acceptance, enter RLAT with BUSY=1 from the next cycle.
REQ-025 SHALL present beat 0 with DOUT_READY=1 exactly RD_LAT cycles after the accept edge.
REQ-026 SHALL, in RBURST, deliver beats on consecutive cycles with the address incrementing, regardless of request inputs.
REQ-027 SHALL hold BUSY=1 through RLAT and RBURST.
REQ-028 SHALL drive DOUT_READY=0 and BUSY=0 in the cycle after the last read beat, returning to IDLE.
REQ-029 SHALL compute the store index as (burst address - BASE) modulo 2^AW, so bursts wrap within the store.
REQ-030 SHALL treat an accepted address outside [BASE, BASE+2^AW) as out of window: writes are discarded, reads return 64'hDEAD_BEEF_DEAD_BEEF with normal timing.
REQ-031 SHALL hold DOUT at its last value while DOUT_READY=0.
REQ-032 SHALL, when STALL_EN=1 and in IDLE or WBURST, raise BUSY for one cycle whenever bits [1:0] of a 16-bit LFSR (seed 16'hACE1, advanced every cycle) equal 2'b00.
REQ-033 SHALL have BUSY depend only on registered state, never combinationally on request inputs.
REQ-034 SHALL, for a read arriving in the cycle after a write to the same address, return the new data.

Reset
REQ-035 SHALL, while RESET is high, force state=IDLE, BUSY=0, DOUT_READY=0, DOUT=0, the beat counter to 0 and the LFSR to its seed.
REQ-036 SHALL abandon any burst in progress on mid-burst reset, with no further beats delivered after release.
REQ-037 SHALL NOT clear backing-store contents on reset.

Structure
REQ-038 SHALL define the state enum, default BASE and the out-of-window pattern constant in shared package ddram_pkg.
REQ-039 SHALL instantiate the backing store as sub-module ddram_bram: a single-port 2^AW x 64 RAM with 8-bit byte-enable write and 1-cycle registered read.
REQ-040 SHALL absorb the 1-cycle read latency of ddram_bram inside RD_LAT.

Verification
REQ-041 Single write ADDR=0x0600_0004, DIN=64'h1122334455667788, BE=8'h0F; then read, burst 1 -> DOUT=64'h0000000055667788 with DOUT_READY exactly 2 cycles after accept.
REQ-042 Write burst 4 at 0x0600_0000 with data 1,2,3,4 and WE low for 2 cycles between beats 1 and 2; then read burst 4 -> beats 1,2,3,4 on 4 consecutive cycles; BUSY=1 from accept+1 until the cycle after the last beat.
REQ-043 Read burst 2 at 0x0600_03FF with AW=10 -> beat 0 from index 1023, beat 1 from index 0.
REQ-044 Read at 0x0500_0000 -> DOUT=64'hDEADBEEFDEADBEEF; a write to the same address leaves the store unchanged.
REQ-045 RD and WE high together in IDLE -> a write is performed and no DOUT_READY occurs.
REQ-046 RESET asserted during beat 1 of a read burst of 4 -> DOUT_READY and BUSY fall immediately, no beats appear after release, and earlier written data reads back intact.

Source files
------------

// File: rtl/ddram_pkg.sv
// ddram_pkg -- shared definitions for the DDRAM responder model.
//   state_t      : responder state machine encoding
//   DEFAULT_BASE : word address of backing-store word 0 (byte 0x3000_0000)
//   OOW_PATTERN  : read data returned for out-of-window bursts
//   LFSR_SEED    : reset value of the stall-insertion LFSR
//   lfsr_next()  : one step of the 16-bit stall LFSR
package ddram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WBURST,
    RLAT,
    RBURST
  } state_t;

  localparam logic [28:0] DEFAULT_BASE = 29'h0600_0000;
  localparam logic [63:0] OOW_PATTERN  = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/ddram_bram.sv
// ddram_bram -- single-port 2^AW x 64 backing store.
//   clk  : clock
//   we   : write enable (qualified per byte by be)
//   be   : byte enables, bit i covers din[8i+7:8i]
//   addr : word index, shared by read and write
//   din  : write data
//   q    : read data, registered one cycle after addr
module ddram_bram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   din,
  output logic [63:0]   q
);

  logic [63:0] mem [2**AW];

  // NOTE: the array has no reset on purpose -- contents must survive a
  // responder reset, and a resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/ddram_responder.sv
// ddram_responder -- behavioural DDRAM slave backed by a small block RAM.
//   DDRAM_CLK        : sole clock
//   RESET            : asynchronous, active-high reset
//   DDRAM_BUSY       : high -> commands and write beats are not accepted
//   DDRAM_BURSTCNT   : burst length in beats (0 treated as 1)
//   DDRAM_ADDR       : 64-bit word address
//   DDRAM_RD/WE      : read request / write request or write beat (WE wins)
//   DDRAM_DIN/BE     : write data and byte enables
//   DDRAM_DOUT       : read data, held while DDRAM_DOUT_READY is low
//   DDRAM_DOUT_READY : one read beat per high cycle
// Reads deliver beat 0 RD_LAT cycles after acceptance; the RAM's own read
// cycle is folded into that latency.
module ddram_responder
  import ddram_pkg::*;
#(
  parameter int          AW       = 10,
  parameter logic [28:0] BASE     = DEFAULT_BASE,
  parameter int          RD_LAT   = 2,
  parameter bit          STALL_EN = 1'b0
) (
  input  logic        DDRAM_CLK,
  input  logic        RESET,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY
);

  state_t        state;
  logic [AW-1:0] ptr;       // next RAM index to write or to read
  logic [7:0]    beat_cnt;  // beats still owed after the current one
  logic [3:0]    lat_cnt;   // cycles left before read beat 0
  logic          oow;       // accepted burst lies outside the window
  logic [15:0]   lfsr;

  logic [28:0]   req_off;
  logic          req_oow;
  logic [7:0]    req_len;
  logic          wr_accept;
  logic          rd_accept;
  logic          beat_accept;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_q;
  logic [63:0]   rd_data;
  logic [15:0]   lfsr_nxt;
  logic          stall_nxt;

  // Offset from BASE; anything at or above 2^AW (including wrap-around from
  // addresses below BASE) is out of window.
  assign req_off  = DDRAM_ADDR - BASE;
  assign req_oow  = (req_off >> AW) != '0;
  assign req_len  = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

  assign wr_accept   = (state == IDLE) && !DDRAM_BUSY && DDRAM_WE;
  assign rd_accept   = (state == IDLE) && !DDRAM_BUSY && DDRAM_RD && !DDRAM_WE;
  assign beat_accept = (state == WBURST) && !DDRAM_BUSY && DDRAM_WE;

  // In IDLE the RAM tracks the request address so that RD_LAT=1 can issue
  // the first read on the accept edge itself.
  assign mem_addr = (state == IDLE) ? req_off[AW-1:0] : ptr;
  assign mem_we   = (wr_accept && !req_oow) || (beat_accept && !oow);
  assign rd_data  = oow ? OOW_PATTERN : mem_q;

  assign lfsr_nxt  = lfsr_next(lfsr);
  assign stall_nxt = STALL_EN && (lfsr_nxt[1:0] == 2'b00);

  ddram_bram #(.AW(AW)) u_bram (
    .clk  (DDRAM_CLK),
    .we   (mem_we),
    .be   (DDRAM_BE),
    .addr (mem_addr),
    .din  (DDRAM_DIN),
    .q    (mem_q)
  );

  // NOTE: every register below uses <= so that all of them sample the
  // pre-edge values; mixing in = here would create order-dependent logic.
  always_ff @(posedge DDRAM_CLK or posedge RESET) begin
    if (RESET) begin
      state            <= IDLE;
      DDRAM_BUSY       <= 1'b0;
      DDRAM_DOUT_READY <= 1'b0;
      DDRAM_DOUT       <= '0;
      beat_cnt         <= '0;
      lat_cnt          <= '0;
      ptr              <= '0;
      oow              <= 1'b0;
      lfsr             <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        IDLE: begin
          DDRAM_BUSY <= stall_nxt;
          oow        <= req_oow;
          if (wr_accept) begin
            ptr      <= req_off[AW-1:0] + AW'(1);
            beat_cnt <= req_len - 8'd1;
            if (req_len != 8'd1) state <= WBURST;
          end else if (rd_accept) begin
            // With RD_LAT=1 beat 0 was already issued on this edge.
            ptr        <= (RD_LAT == 1) ? req_off[AW-1:0] + AW'(1) : req_off[AW-1:0];
            beat_cnt   <= req_len - 8'd1;
            lat_cnt    <= 4'(RD_LAT - 1);
            DDRAM_BUSY <= 1'b1;
            state      <= RLAT;
          end
        end

        WBURST: begin
          DDRAM_BUSY <= stall_nxt;
          if (beat_accept) begin
            ptr      <= ptr + AW'(1);
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd1) state <= IDLE;
          end
        end

        RLAT: begin
          // RAM reads start one edge before the data is needed on DOUT.
          if (lat_cnt <= 4'd1) ptr <= ptr + AW'(1);
          if (lat_cnt == 4'd0) begin
            DDRAM_DOUT_READY <= 1'b1;
            DDRAM_DOUT       <= rd_data;
            state            <= RBURST;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        RBURST: begin
          ptr <= ptr + AW'(1);
          if (beat_cnt == 8'd0) begin
            DDRAM_DOUT_READY <= 1'b0;
            DDRAM_BUSY       <= 1'b0;
            state            <= IDLE;
          end else begin
            DDRAM_DOUT <= rd_data;
            beat_cnt   <= beat_cnt - 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
